spi_target: RTL

- CPU-bus SPI target (slave) peripheral; the responder end of the SPI link that sdcardio drives as master.
- Lets the board be driven by an external SPI master, e.g. another p601zero board or a debug host.
- Sits on the cpu68 bus as one DSx sub-range, like simpleio/uartio.
- Has a register interface and an irq that is ORed into sys_irq.

---
 rtl/spi_target.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_target.sv
// SPI mode-0 target peripheral on the cpu68 bus: synchronised SPI inputs, byte FSM, DATA/STATUS/CTRL registers.
// Optional feature macro SPI_TARGET_RXFIFO_EN: 4-entry receive FIFO instead of a single rx_buf.
`timescale 1ns/1ps
module spi_target #(
    parameter int         SYNC_STAGES   = 2,
    parameter logic [7:0] UNDERRUN_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    output logic       irq,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    input  logic       ssel_n,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    // Synchroniser lanes: bit0 sck, bit1 ssel_n (idles high), bit2 mosi.
    localparam logic [2:0] SYNC_RST = 3'b010;
    logic [2:0] sync_in;
    logic [2:0] sync_out;
    assign sync_in = {mosi, ssel_n, sck};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    chain_reg <= {SYNC_STAGES{SYNC_RST[gi]}};
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], sync_in[gi]};
                end
            end
            assign sync_out[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    logic sck_s, ssel_s, mosi_s;
    assign sck_s  = sync_out[0];
    assign ssel_s = sync_out[1];
    assign mosi_s = sync_out[2];

    logic sck_prev_reg, ssel_prev_reg;
    logic sck_rise, sck_fall, ssel_fall, selected;
    assign sck_rise  = sck_s & ~sck_prev_reg;
    assign sck_fall  = ~sck_s & sck_prev_reg;
    assign ssel_fall = ~ssel_s & ssel_prev_reg;
    assign selected  = ~ssel_s;

    state_t     state_reg, state_next;
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] tx_shift_reg, tx_shift_next;
    logic [7:0] rx_shift_reg, rx_shift_next;
    logic [7:0] tx_buf_reg, tx_buf_next;
    logic       tx_empty_reg, tx_empty_next;
    logic       overrun_reg, overrun_next;
    logic       rx_ie_reg, rx_ie_next;
    logic       tx_ie_reg, tx_ie_next;
    logic       enable_reg, enable_next;
    logic       irq_reg, irq_next;

    logic       cpu_wr, data_rd, byte_done;
    logic [7:0] rx_byte;
    logic       rx_full, fifo_full;
    logic [7:0] rx_head;

    assign cpu_wr  = cs & ~rw;
    assign data_rd = cs & rw & (AD == 3'd0);
    assign rx_byte = {rx_shift_reg[6:0], mosi_s};

`ifdef SPI_TARGET_RXFIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr_reg, wr_ptr_next;
    logic [1:0] rd_ptr_reg, rd_ptr_next;
    logic [2:0] count_reg, count_next;
    logic       push, pop;

    assign rx_full   = (count_reg != 3'd0);
    assign fifo_full = (count_reg == 3'd4);
    assign rx_head   = fifo_mem[rd_ptr_reg];
    assign push      = byte_done & ~fifo_full;
    assign pop       = data_rd & rx_full;

    always_comb begin
        wr_ptr_next = wr_ptr_reg + {1'b0, push};
        rd_ptr_next = rd_ptr_reg + {1'b0, pop};
        count_next  = count_reg + {2'b00, push} - {2'b00, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) fifo_mem[i] <= 8'h00;
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else begin
            if (push) fifo_mem[wr_ptr_reg] <= rx_byte;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end
`else
    logic [7:0] rx_buf_reg, rx_buf_next;
    logic       rx_full_reg, rx_full_next;

    assign rx_full   = rx_full_reg;
    assign fifo_full = 1'b0;
    assign rx_head   = rx_buf_reg;

    // A completing byte may reuse the buffer the CPU is reading in the same cycle.
    always_comb begin
        rx_buf_next  = rx_buf_reg;
        rx_full_next = rx_full_reg;
        if (data_rd) rx_full_next = 1'b0;
        if (byte_done && (!rx_full_reg || data_rd)) begin
            rx_buf_next  = rx_byte;
            rx_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_buf_reg  <= 8'h00;
            rx_full_reg <= 1'b0;
        end else begin
            rx_buf_reg  <= rx_buf_next;
            rx_full_reg <= rx_full_next;
        end
    end
`endif

    logic byte_drop;
`ifdef SPI_TARGET_RXFIFO_EN
    assign byte_drop = byte_done & fifo_full;
`else
    assign byte_drop = byte_done & rx_full_reg & ~data_rd;
`endif

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        tx_buf_next   = tx_buf_reg;
        tx_empty_next = tx_empty_reg;
        overrun_next  = overrun_reg;
        rx_ie_next    = rx_ie_reg;
        tx_ie_next    = tx_ie_reg;
        enable_next   = enable_reg;
        byte_done     = 1'b0;

        if (!selected || !enable_reg) begin
            state_next   = IDLE;
            bit_cnt_next = 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ssel_fall) state_next = LOAD;
                end
                LOAD: begin
                    tx_shift_next = tx_empty_reg ? UNDERRUN_BYTE : tx_buf_reg;
                    tx_empty_next = 1'b1;
                    bit_cnt_next  = 4'd0;
                    state_next    = SHIFT;
                end
                SHIFT: begin
                    if (sck_rise) begin
                        rx_shift_next = rx_byte;
                        bit_cnt_next  = bit_cnt_reg + 4'd1;
                        byte_done     = (bit_cnt_reg == 4'd7);
                    end else if (sck_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            state_next = LOAD;
                        end else if (bit_cnt_reg != 4'd0) begin
                            tx_shift_next = {tx_shift_reg[6:0], 1'b0};
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // CPU writes are applied after the FSM so a DATA write beats LOAD's tx_empty set.
        if (cpu_wr) begin
            case (AD)
                3'd0: begin
                    tx_buf_next   = DI;
                    tx_empty_next = 1'b0;
                end
                3'd1: if (DI[2]) overrun_next = 1'b0;
                3'd2: begin
                    rx_ie_next  = DI[0];
                    tx_ie_next  = DI[1];
                    enable_next = DI[7];
                end
                default: ;
            endcase
        end
        if (byte_drop) overrun_next = 1'b1;

        irq_next = (rx_ie_reg & rx_full) | (tx_ie_reg & tx_empty_reg & enable_reg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_prev_reg  <= 1'b0;
            ssel_prev_reg <= 1'b1;
            state_reg     <= IDLE;
            bit_cnt_reg   <= 4'd0;
            tx_shift_reg  <= 8'h00;
            rx_shift_reg  <= 8'h00;
            tx_buf_reg    <= 8'h00;
            tx_empty_reg  <= 1'b1;
            overrun_reg   <= 1'b0;
            rx_ie_reg     <= 1'b0;
            tx_ie_reg     <= 1'b0;
            enable_reg    <= 1'b0;
            irq_reg       <= 1'b0;
        end else begin
            sck_prev_reg  <= sck_s;
            ssel_prev_reg <= ssel_s;
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            tx_shift_reg  <= tx_shift_next;
            rx_shift_reg  <= rx_shift_next;
            tx_buf_reg    <= tx_buf_next;
            tx_empty_reg  <= tx_empty_next;
            overrun_reg   <= overrun_next;
            rx_ie_reg     <= rx_ie_next;
            tx_ie_reg     <= tx_ie_next;
            enable_reg    <= enable_next;
            irq_reg       <= irq_next;
        end
    end

    always_comb begin
        DO = 8'h00;
        case (AD)
            3'd0: DO = rx_head;
            3'd1: DO = {3'b000, fifo_full, selected, overrun_reg, tx_empty_reg, rx_full};
            3'd2: DO = {enable_reg, 5'b00000, tx_ie_reg, rx_ie_reg};
            default: DO = 8'h00;
        endcase
    end

    assign irq     = irq_reg;
    assign miso_oe = selected & enable_reg;
    assign miso    = (selected & enable_reg) ? tx_shift_reg[7] : 1'b1;

endmodule
